// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_rr
// Description : Two-initiator round-robin bus arbiter with target datapath mux
//               and registered read-data return to the current/previous owner.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 8,
    parameter int HOLD_LIMIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core0_request,
    output logic              core0_grant,
    input  logic [ADDR_W-1:0] core0_address,
    input  logic              core0_rw,
    input  logic [DATA_W-1:0] core0_data_in,
    output logic [DATA_W-1:0] core0_data_out,
    input  logic              core1_request,
    output logic              core1_grant,
    input  logic [ADDR_W-1:0] core1_address,
    input  logic              core1_rw,
    input  logic [DATA_W-1:0] core1_data_in,
    output logic [DATA_W-1:0] core1_data_out,
    output logic [ADDR_W-1:0] RAM_address,
    output logic              RAM_rw,
    output logic [DATA_W-1:0] RAM_data_in,
    input  logic [DATA_W-1:0] RAM_data_out,
    output logic [1:0]        owner
);

    localparam int TW = (HOLD_LIMIT < 1) ? 1 : $clog2(HOLD_LIMIT + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_GNT0 = 2'd1;
    localparam logic [1:0] c_GNT1 = 2'd2;
    localparam logic [1:0] c_REL  = 2'd3;

    localparam logic [1:0] c_OWN_NONE = 2'b00;
    localparam logic [1:0] c_OWN_C0   = 2'b01;
    localparam logic [1:0] c_OWN_C1   = 2'b10;

    localparam logic [TW-1:0] c_LIMIT    = TW'(HOLD_LIMIT);
    localparam logic [TW-1:0] c_LIMIT_M1 = TW'((HOLD_LIMIT > 0) ? HOLD_LIMIT - 1 : 0);

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic          r_last_owner;   // 0 = core0, 1 = core1
    logic [TW-1:0] r_tenure;
    logic [1:0]    r_prev_owner;
    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;
    logic [1:0]    w_owner;
    logic          w_hold_hit;

    // The current cycle is the HOLD_LIMIT-th granted cycle (or beyond).
    assign w_hold_hit = (HOLD_LIMIT != 0) && (r_tenure >= c_LIMIT_M1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (core0_request && !core1_request) begin
                    w_next = c_GNT0;
                end else if (core1_request && !core0_request) begin
                    w_next = c_GNT1;
                end else if (core0_request && core1_request) begin
                    w_next = r_last_owner ? c_GNT0 : c_GNT1;
                end
            end
            c_GNT0: begin
                if (!core0_request || (w_hold_hit && core1_request)) begin
                    w_next = c_REL;
                end
            end
            c_GNT1: begin
                if (!core1_request || (w_hold_hit && core0_request)) begin
                    w_next = c_REL;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_owner     = c_OWN_NONE;
        RAM_address = '0;
        RAM_rw      = 1'b0;
        RAM_data_in = '0;
        case (r_state)
            c_GNT0: begin
                w_owner     = c_OWN_C0;
                RAM_address = core0_address;
                RAM_rw      = core0_rw;
                RAM_data_in = core0_data_in;
            end
            c_GNT1: begin
                w_owner     = c_OWN_C1;
                RAM_address = core1_address;
                RAM_rw      = core1_rw;
                RAM_data_in = core1_data_in;
            end
            default: ;
        endcase
    end

    assign owner       = w_owner;
    assign core0_grant = (r_state == c_GNT0);
    assign core1_grant = (r_state == c_GNT1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_owner <= 1'b1;
            r_tenure     <= '0;
        end else begin
            if ((r_state == c_GNT0) && (w_next == c_REL)) begin
                r_last_owner <= 1'b0;
            end else if ((r_state == c_GNT1) && (w_next == c_REL)) begin
                r_last_owner <= 1'b1;
            end
            // Zero outside a tenure, so every new grant starts counting from 0.
            if ((r_state == c_GNT0) || (r_state == c_GNT1)) begin
                if (r_tenure < c_LIMIT) begin
                    r_tenure <= r_tenure + 1'b1;
                end
            end else begin
                r_tenure <= '0;
            end
        end
    end

    // Target read data lags the address by one cycle, so it goes to last cycle's owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_owner <= c_OWN_NONE;
            r_data0      <= '0;
            r_data1      <= '0;
        end else begin
            r_prev_owner <= w_owner;
            if (r_prev_owner == c_OWN_C0) begin
                r_data0 <= RAM_data_out;
            end
            if (r_prev_owner == c_OWN_C1) begin
                r_data1 <= RAM_data_out;
            end
        end
    end

    assign core0_data_out = r_data0;
    assign core1_data_out = r_data1;

endmodule
`default_nettype wire
